// File: rtl/aes_pkg.sv
// Shared AES definitions: byte addressing, the InvShiftRows index map and the
// state encoding used by the decryption-side round datapath.
package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte k of a state lives at bits [127-8k -: 8]; {~k, 3'b000} is 8*(15-k).
  function automatic logic [7:0] byte_at(input logic [127:0] state, input logic [3:0] k);
    return state[{~k, 3'b000} +: 8];
  endfunction

  // Source byte index for InvShiftRows: out(r,c) = in(r,(c-r) mod 4).
  // Byte k sits at row k%4 and column k/4, so the mod-4 arithmetic is a 2-bit subtract.
  function automatic logic [3:0] inv_shift_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2];
    return {c - r, r};
  endfunction

endpackage

// File: rtl/sbox.sv
// AES S-box, forward (ctrl=0) or inverse (ctrl=1), computed from the GF(2^8)
// inverse and the affine transform rather than a lookup table.
module sbox (
  input  logic       ctrl,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Select the substitution direction.
  always_comb begin
    if (ctrl) begin
      out_byte = gf_inv(inv_affine(in_byte));
    end else begin
      out_byte = affine(gf_inv(in_byte));
    end
  end

endmodule

// File: rtl/inv_sub_shift_serial.sv
// InvShiftRows applied while loading the state, then InvSubBytes performed
// LANES bytes per cycle through inverse S-boxes; valid/ready on both sides.
module inv_sub_shift_serial
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_shift_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  // cnt steps by LANES and wraps to 0 after the last group (STEP is 0 for LANES=16).
  localparam logic [3:0] STEP     = 4'(LANES);
  localparam logic [3:0] LAST_CNT = 4'(AES_BYTES - LANES);

  state_t       state_reg;
  state_t       state_next;
  logic [3:0]   cnt_reg;
  logic [127:0] src_reg;
  logic [127:0] dst_reg;
  logic [127:0] dst_next;
  logic [127:0] shifted;
  logic         load;
  logic [3:0]   lane_idx [LANES];
  logic [7:0]   lane_in  [LANES];
  logic [7:0]   lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = cnt_reg + 4'(l);
    assign lane_in[l]  = byte_at(src_reg, lane_idx[l]);
    sbox u_sbox (
      .ctrl     (1'b1),
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  // InvShiftRows of the incoming state, captured into src_reg on load.
  always_comb begin
    shifted = '0;
    for (int k = 0; k < AES_BYTES; k++) begin
      shifted[{~4'(k), 3'b000} +: 8] = byte_at(in_state, inv_shift_idx(4'(k)));
    end
  end

  // Merge this cycle's substituted group into the result buffer.
  always_comb begin
    dst_next = dst_reg;
    for (int l = 0; l < LANES; l++) begin
      dst_next[{~lane_idx[l], 3'b000} +: 8] = lane_out[l];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DONE with a simultaneous hand-off and new input goes straight to SUB.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) state_next = SUB;
        else          state_next = IDLE;
      end
      SUB: begin
        if (cnt_reg == LAST_CNT) state_next = DONE;
        else                     state_next = SUB;
      end
      DONE: begin
        if (out_ready) state_next = in_valid ? SUB : IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register; in_ready never looks at in_valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      SUB: begin
        busy = 1'b1;
      end
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign load      = in_ready & in_valid;
  assign out_state = dst_reg;

  // Datapath: load overwrites only src_reg; dst_reg changes only during SUB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
      src_reg <= 128'd0;
      dst_reg <= 128'd0;
    end else if (load) begin
      cnt_reg <= 4'd0;
      src_reg <= shifted;
    end else if (state_reg == SUB) begin
      cnt_reg <= cnt_reg + STEP;
      dst_reg <= dst_next;
    end else begin
      cnt_reg <= cnt_reg;
    end
  end

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// Bench for inv_sub_shift_serial: three instances (LANES = 1, 16, 4) exercised
// one after another; expected results are queued at acceptance and checked by
// an independent monitor when each result is presented.
module tb_inv_sub_shift_serial;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_state [NDUT];
  logic         busy      [NDUT];

  int           out_mode [NDUT] = '{1, 1, 1};  // 0 = hold low, 1 = high, 2 = random
  logic [127:0] q_data [NDUT][$];
  longint       q_acc  [NDUT][$];
  longint       cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   isb [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_shift_serial #(.LANES((g == 0) ? 1 : ((g == 1) ? 16 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lanes_of(input int d);
    case (d)
      0:       return 1;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x * 2;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  task automatic build_table();
    logic [7:0] c;
    logic [7:0] v;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
      end
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] with_byte(input logic [127:0] s, input logic [3:0] k, input logic [7:0] v);
    s[{~k, 3'b000} +: 8] = v;
    return s;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o;
    int           r;
    int           c;
    for (int k = 0; k < 16; k++) b[k] = s[{~4'(k), 3'b000} +: 8];
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      o[{~4'(k), 3'b000} +: 8] = isb[b[4 * ((c - r + 4) % 4) + r]];
    end
    return o;
  endfunction

  task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d (LANES=%0d) at cycle %0d: got %h expected %h", name, d, lanes_of(d), cyc, act, exp);
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    for (int d = 0; d < NDUT; d++) out_ready[d] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < NDUT; d++) begin
        out_ready[d] = (out_mode[d] == 2) ? 1'($urandom_range(0, 1)) : (out_mode[d] == 1);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev [NDUT];
    for (int d = 0; d < NDUT; d++) prev[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (out_valid[d] === 1'b1) begin
          if (q_data[d].size() == 0) begin
            check("unexpected_out_valid", d, 128'(out_valid[d]), 128'(0));
          end else begin
            if (!prev[d]) begin
              check("latency", d, 128'(cyc - q_acc[d][0]), 128'(16 / lanes_of(d)));
              check("data_first", d, out_state[d], q_data[d][0]);
            end
            if (out_ready[d]) begin
              check("data_handoff", d, out_state[d], q_data[d][0]);
              void'(q_data[d].pop_front());
              void'(q_acc[d].pop_front());
            end
          end
          check("in_ready_in_done", d, 128'(in_ready[d]), 128'(out_ready[d]));
          check("busy_in_done", d, 128'(busy[d]), 128'(1));
        end else begin
          check("in_ready_vs_busy", d, 128'(in_ready[d]), 128'(!busy[d]));
        end
        prev[d] = out_valid[d];
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input int d, input logic [127:0] st, input logic [127:0] exp);
    bit done;
    done = 1'b0;
    in_state[d] = st;
    in_valid[d] = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        q_data[d].push_back(exp);
        q_acc[d].push_back(cyc + 1);
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", d, 128'(in_ready[d]), 128'(1));
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (q_data[d].size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q_data[d].size() != 0) begin
      check("drain_timeout", d, 128'(q_data[d].size()), 128'(0));
      q_data[d].delete();
      q_acc[d].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_test(input int d);
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] ea;
    int           t;
    a  = {$urandom, $urandom, $urandom, $urandom};
    b  = {$urandom, $urandom, $urandom, $urandom};
    ea = model(a);
    out_mode[d] = 0;
    @(posedge clk);
    #1;
    send(d, a, ea);
    t = 0;
    while (out_valid[d] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("hold_reach_done", d, 128'(out_valid[d]), 128'(1));
    in_state[d] = b;
    in_valid[d] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_in_ready", d, 128'(in_ready[d]), 128'(0));
      check("hold_out_state", d, out_state[d], ea);
    end
    @(posedge clk);
    #1;
    out_mode[d] = 1;
    send(d, b, model(b));
    drain(d);
  endtask

  task automatic reset_test(input int d);
    int w;
    logic [127:0] s;
    w = (16 / lanes_of(d) > 5) ? 5 : (16 / lanes_of(d) - 1);
    s = {$urandom, $urandom, $urandom, $urandom};
    send(d, s, model(s));
    repeat (w) @(posedge clk);
    #1;
    check("busy_before_rst", d, 128'(busy[d]), 128'(1));
    rst = 1'b1;
    q_data[d].delete();
    q_acc[d].delete();
    #1;
    check("rst_out_valid", d, 128'(out_valid[d]), 128'(0));
    check("rst_in_ready", d, 128'(in_ready[d]), 128'(1));
    check("rst_busy", d, 128'(busy[d]), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", d, 128'(in_ready[d]), 128'(1));
    check("out_state_after_rst", d, out_state[d], 128'(0));
    repeat (20) @(posedge clk);
    #1;
    send(d, 128'(0), {16{8'h52}});
    drain(d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] s;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0;
      in_state[d] = 128'(0);
    end
    build_table();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset_out_valid", d, 128'(out_valid[d]), 128'(0));
      check("reset_in_ready", d, 128'(in_ready[d]), 128'(1));
      check("reset_busy", d, 128'(busy[d]), 128'(0));
      check("reset_out_state", d, out_state[d], 128'(0));
    end
    @(posedge clk);
    #1;

    for (int d = 0; d < NDUT; d++) begin
      out_mode[d] = 1;
      send(d, 128'(0), {16{8'h52}});
      send(d, {16{8'h63}}, 128'(0));
      send(d, {16{8'h16}}, {16{8'hff}});
      send(d, with_byte({16{8'h63}}, 4'd1, 8'h16), with_byte(128'(0), 4'd5, 8'hff));
      send(d, with_byte({16{8'h63}}, 4'd0, 8'hed), with_byte(128'(0), 4'd0, 8'h53));
      drain(d);

      hold_test(d);
      reset_test(d);

      out_mode[d] = 2;
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        s = {$urandom, $urandom, $urandom, $urandom};
        send(d, s, model(s));
      end
      drain(d);
      out_mode[d] = 1;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
